// File: rtl/inst_rom_arb.sv
// inst_rom_arb: two-port arbiter in front of a combinational instruction ROM.
// The fetch port has priority. A debug/loader request that keeps losing to
// fetch is granted once it has lost STARVE_MAX cycles in a row. Each grant
// produces a single-cycle response one clock later, steered to the owner
// that was recorded at the grant edge. Misaligned addresses never enable the
// ROM; they return an error with zero data.
module inst_rom_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,

  // Fetch port
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic        f_err,
  output logic [31:0] f_rdata,

  // Debug / loader port
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic        d_err,
  output logic [31:0] d_rdata,

  // Instruction ROM
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst
);

  // Enough bits to hold 0..STARVE_MAX; at least one bit so the counter exists.
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  // Owner identity of the response in flight.
  localparam logic OWNER_F = 1'b0;
  localparam logic OWNER_D = 1'b1;

  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;
  logic             gnt_any;
  logic [31:0]      gnt_addr;
  logic             gnt_aligned;
  logic [31:0]      rom_word;

  logic             resp_valid;
  logic             resp_owner;

  // Debug is overdue once it is pending and has already lost STARVE_MAX times.
  assign starve_hit = d_req && (starve_cnt == CNT_MAX);

  // Fetch wins unless debug is overdue; debug takes any cycle fetch is idle.
  assign f_gnt   = f_req && !starve_hit;
  assign d_gnt   = d_req && (!f_req || starve_hit);
  assign gnt_any = f_gnt || d_gnt;

  // Select the granted address and decide whether the ROM may be enabled.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // a variable unassigned and infer a latch.
  always_comb begin
    gnt_addr = 32'h0;
    if (f_gnt) begin
      gnt_addr = f_addr;
    end else if (d_gnt) begin
      gnt_addr = d_addr;
    end
  end

  assign gnt_aligned = (gnt_addr[1:0] == 2'b00);
  assign rom_ce      = gnt_any && gnt_aligned;
  assign rom_addr    = rom_ce ? gnt_addr : 32'h0;

  // A misaligned grant returns zero data instead of whatever the ROM shows.
  assign rom_word = rom_ce ? rom_inst : 32'h0;

  // Count consecutive losses of a pending debug request; saturate at the limit.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!d_req || d_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Record whether a response is due next cycle and which port owns it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= 1'b0;
      resp_owner <= OWNER_F;
    end else begin
      resp_valid <= gnt_any;
      if (gnt_any) begin
        resp_owner <= d_gnt ? OWNER_D : OWNER_F;
      end
    end
  end

  // Fetch response payload: loaded only on a fetch grant, held otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_rdata <= 32'h0;
      f_err   <= 1'b0;
    end else if (f_gnt) begin
      f_rdata <= rom_word;
      f_err   <= !gnt_aligned;
    end
  end

  // Debug response payload: loaded only on a debug grant, held otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_rdata <= 32'h0;
      d_err   <= 1'b0;
    end else if (d_gnt) begin
      d_rdata <= rom_word;
      d_err   <= !gnt_aligned;
    end
  end

  // Steer the single response strobe to the registered owner.
  assign f_rvalid = resp_valid && (resp_owner == OWNER_F);
  assign d_rvalid = resp_valid && (resp_owner == OWNER_D);

endmodule
